// File: rtl/twos_float_pkg.sv
// Shared widths and stage payload for the two's-complement to float pipeline.
// Optional rounding is enabled by defining TWOS_FLOAT_ROUND_EN.
package twos_float_pkg;

  // Default build widths; the stage payload below is sized from these.
  localparam int unsigned DEF_IN_W  = 12;
  localparam int unsigned DEF_EXP_W = 3;
  localparam int unsigned DEF_MAN_W = 4;

  localparam int unsigned MAG_W = DEF_IN_W - 1;
  localparam int unsigned EMAX  = (1 << DEF_EXP_W) - 1;
  localparam int unsigned LZ_W  = $clog2(MAG_W + 1);

  // Normalised word travelling from stage 2 to stage 3.
  typedef struct packed {
    logic                 s;
    logic [DEF_EXP_W-1:0] e;
    logic [DEF_MAN_W-1:0] f;
    logic                 rnd;
    logic                 sat;
  } stage_t;

endpackage

// File: rtl/twos_to_float_pipe_if.sv
// Valid/ready stream bundle: integer words in, float fields out.
interface twos_to_float_pipe_if
  import twos_float_pkg::*;
#(
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned EXP_W = DEF_EXP_W,
  parameter int unsigned MAN_W = DEF_MAN_W
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_s;
  logic [EXP_W-1:0] out_e;
  logic [MAN_W-1:0] out_f;
  logic             out_sat;

  // Converter side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_s, out_e, out_f, out_sat
  );

  // Producer/consumer side.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_s, out_e, out_f, out_sat
  );
endinterface

// File: rtl/twos_float_lzc.sv
// Combinational leading-zero counter; returns W for an all-zero word.
module twos_float_lzc #(
  parameter int unsigned W  = 11,
  parameter int unsigned CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  data_i,
  output logic [CW-1:0] cnt_c
);

  // Highest set bit wins because it is visited last.
  always_comb begin
    cnt_c = CW'(W);
    for (int i = 0; i < int'(W); i++) begin
      if (data_i[i]) cnt_c = CW'(int'(W) - 1 - i);
    end
  end

endmodule

// File: rtl/twos_to_float_pipe.sv
// Three-stage two's-complement to sign/exponent/significand converter with
// valid/ready backpressure. Define TWOS_FLOAT_ROUND_EN for round-half-up,
// otherwise the significand is truncated.
module twos_to_float_pipe
  import twos_float_pkg::*;
#(
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned EXP_W = DEF_EXP_W,
  parameter int unsigned MAN_W = DEF_MAN_W
) (
  input logic                 clk,
  input logic                 rst_n,
  twos_to_float_pipe_if.slave bus
);

`ifdef TWOS_FLOAT_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  // The stage payload struct is sized by the package, so widths are changed there.
  if (IN_W != DEF_IN_W || EXP_W != DEF_EXP_W || MAN_W != DEF_MAN_W) begin : g_cfg_mismatch
    $error("twos_to_float_pipe: parameters must match twos_float_pkg defaults");
  end
  if (IN_W < 4 || MAN_W >= MAG_W || EMAX < MAG_W - MAN_W) begin : g_cfg_bad
    $error("twos_to_float_pipe: illegal width combination");
  end

  logic             advance_c;
  logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic             s1_s_q, s1_s_d, s1_sat_q, s1_sat_d;
  logic [MAG_W-1:0] s1_m_q, s1_m_d, mag_neg_c;
  stage_t           s2_q, s2_d;
  logic [LZ_W-1:0]  lz_c;
  logic [MAN_W:0]   top_c;
  logic             out_s_q, out_s_d, out_sat_q, out_sat_d;
  logic [EXP_W-1:0] out_e_q, out_e_d;
  logic [MAN_W-1:0] out_f_q, out_f_d;

  // Whole pipe moves together whenever the output slot is free or draining.
  assign advance_c    = bus.out_ready | ~v3_q;
  assign bus.in_ready = advance_c;

  // Stage 1: sign-magnitude split, clamping the most-negative word.
  always_comb begin
    v1_d      = v1_q;
    s1_s_d    = s1_s_q;
    s1_m_d    = s1_m_q;
    s1_sat_d  = s1_sat_q;
    mag_neg_c = ~bus.in_data[MAG_W-1:0] + MAG_W'(1);
    if (advance_c) begin
      v1_d     = bus.in_valid;
      s1_s_d   = bus.in_data[IN_W-1];
      s1_sat_d = 1'b0;
      if (!bus.in_data[IN_W-1]) begin
        s1_m_d = bus.in_data[MAG_W-1:0];
      end else if (bus.in_data[MAG_W-1:0] == '0) begin
        s1_m_d   = '1;
        s1_sat_d = 1'b1;
      end else begin
        s1_m_d = mag_neg_c;
      end
    end
  end

  twos_float_lzc #(.W(MAG_W), .CW(LZ_W)) u_lzc (
    .data_i (s1_m_q),
    .cnt_c  (lz_c)
  );

  // Leading one aligned to the top, keep MAN_W bits plus the round bit.
  assign top_c = (MAN_W + 1)'((s1_m_q << lz_c) >> (MAG_W - MAN_W - 1));

  // Stage 2: normalise; small magnitudes stay denormal with E = 0.
  always_comb begin
    v2_d = v2_q;
    s2_d = s2_q;
    if (advance_c) begin
      v2_d     = v1_q;
      s2_d.s   = s1_s_q;
      s2_d.sat = s1_sat_q;
      if (32'(lz_c) >= MAG_W - MAN_W) begin
        s2_d.e   = '0;
        s2_d.f   = s1_m_q[MAN_W-1:0];
        s2_d.rnd = 1'b0;
      end else begin
        s2_d.e   = EXP_W'(MAG_W - MAN_W - 32'(lz_c));
        s2_d.f   = top_c[MAN_W:1];
        s2_d.rnd = top_c[0];
      end
    end
  end

  // Stage 3: optional round with carry into the exponent or saturation.
  always_comb begin
    v3_d      = v3_q;
    out_s_d   = out_s_q;
    out_e_d   = out_e_q;
    out_f_d   = out_f_q;
    out_sat_d = out_sat_q;
    if (advance_c) begin
      v3_d      = v2_q;
      out_s_d   = s2_q.s;
      out_e_d   = s2_q.e;
      out_f_d   = s2_q.f;
      out_sat_d = s2_q.sat;
      if (ROUND_EN && s2_q.rnd) begin
        if (&s2_q.f) begin
          if (32'(s2_q.e) == EMAX) begin
            out_f_d   = '1;
            out_sat_d = 1'b1;
          end else begin
            out_f_d = MAN_W'(1) << (MAN_W - 1);
            out_e_d = s2_q.e + EXP_W'(1);
          end
        end else begin
          out_f_d = s2_q.f + MAN_W'(1);
        end
      end
    end
  end

  // Pipeline registers; reset flushes every in-flight word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      s1_s_q    <= 1'b0;
      s1_m_q    <= '0;
      s1_sat_q  <= 1'b0;
      s2_q      <= '0;
      out_s_q   <= 1'b0;
      out_e_q   <= '0;
      out_f_q   <= '0;
      out_sat_q <= 1'b0;
    end else begin
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      v3_q      <= v3_d;
      s1_s_q    <= s1_s_d;
      s1_m_q    <= s1_m_d;
      s1_sat_q  <= s1_sat_d;
      s2_q      <= s2_d;
      out_s_q   <= out_s_d;
      out_e_q   <= out_e_d;
      out_f_q   <= out_f_d;
      out_sat_q <= out_sat_d;
    end
  end

  assign bus.out_valid = v3_q;
  assign bus.out_s     = out_s_q;
  assign bus.out_e     = out_e_q;
  assign bus.out_f     = out_f_q;
  assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_twos_to_float_pipe.sv
// Self-checking bench for twos_to_float_pipe (honours TWOS_FLOAT_ROUND_EN).
module tb_twos_to_float_pipe;
  import twos_float_pkg::*;

  localparam int unsigned IN_W  = DEF_IN_W;
  localparam int unsigned EXP_W = DEF_EXP_W;
  localparam int unsigned MAN_W = DEF_MAN_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  twos_to_float_pipe_if #(.IN_W(IN_W), .EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

  twos_to_float_pipe #(.IN_W(IN_W), .EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit s;
    int e;
    int f;
    bit sat;
  } exp_t;

  // Reference: value-level conversion from the signed integer.
  function automatic exp_t model(input int d);
    exp_t r;
    int mag, msb, e, f, rnd;
    r.sat = 1'b0;
    r.s   = (d < 0);
    mag   = (d < 0) ? -d : d;
    if (mag > (1 << MAG_W) - 1) begin
      mag   = (1 << MAG_W) - 1;
      r.sat = 1'b1;
    end
    msb = -1;
    for (int i = 0; i < int'(MAG_W); i++) if (mag >= (1 << i)) msb = i;
    e   = (msb >= int'(MAN_W)) ? msb - (int'(MAN_W) - 1) : 0;
    f   = mag >> e;
    rnd = (e > 0) ? ((mag >> (e - 1)) & 1) : 0;
`ifdef TWOS_FLOAT_ROUND_EN
    f = f + rnd;
    if (f == (1 << MAN_W)) begin
      if (e < int'(EMAX)) begin
        f = 1 << (MAN_W - 1);
        e = e + 1;
      end else begin
        f     = (1 << MAN_W) - 1;
        r.sat = 1'b1;
      end
    end
`else
    rnd = 0;
`endif
    r.e = e;
    r.f = f;
    return r;
  endfunction

  function automatic int to_int(input logic [IN_W-1:0] w);
    return int'($signed(w));
  endfunction

  task automatic test_reset;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_s !== 1'b0 || bus.out_e !== '0 ||
        bus.out_f !== '0 || bus.out_sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b s=%b e=%0d f=%0d sat=%b exp all 0",
               bus.out_valid, bus.out_s, bus.out_e, bus.out_f, bus.out_sat);
    end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b exp 1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %b exp 0", bus.out_valid);
    end
  endtask

  task automatic test_directed;
    logic [IN_W-1:0] dv [7];
    bit ev_s [7];
    int ev_e [7];
    int ev_f [7];
    bit ev_sat [7];
    int lat;
    dv    = '{12'd422, 12'hE5A, 12'd125, 12'd2047, 12'h800, 12'd5, 12'd0};
    ev_s  = '{0, 1, 0, 0, 1, 0, 0};
`ifdef TWOS_FLOAT_ROUND_EN
    ev_e   = '{5, 5, 4, 7, 7, 0, 0};
    ev_f   = '{13, 13, 8, 15, 15, 5, 0};
    ev_sat = '{0, 0, 0, 1, 1, 0, 0};
`else
    ev_e   = '{5, 5, 3, 7, 7, 0, 0};
    ev_f   = '{13, 13, 15, 15, 15, 5, 0};
    ev_sat = '{0, 0, 0, 0, 1, 0, 0};
`endif
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_data   = dv[i];
      bus.in_valid  = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL directed_in_ready d=%h got %b exp 1", dv[i], bus.in_ready);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat = 0;
      for (int k = 1; k <= 8; k++) begin
        if (bus.out_valid === 1'b1) begin
          lat = k;
          break;
        end
        @(negedge clk);
      end
      checks++;
      if (lat != 3) begin
        errors++;
        $display("FAIL directed_latency d=%h got %0d exp 3", dv[i], lat);
      end
      checks++;
      if (bus.out_s !== ev_s[i] || bus.out_e !== EXP_W'(ev_e[i]) ||
          bus.out_f !== MAN_W'(ev_f[i]) || bus.out_sat !== ev_sat[i]) begin
        errors++;
        $display("FAIL directed_fields d=%h got s=%b e=%0d f=%0d sat=%b exp s=%b e=%0d f=%0d sat=%b",
                 dv[i], bus.out_s, bus.out_e, bus.out_f, bus.out_sat,
                 ev_s[i], ev_e[i], ev_f[i], ev_sat[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    int acc, got;
    exp_t x;
    logic [EXP_W-1:0] held_e;
    logic [MAN_W-1:0] held_f;
    @(negedge clk);
    bus.out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = IN_W'(acc + 1);
      #1;
      if (bus.in_ready === 1'b1) acc++;
    end
    checks++;
    if (acc != 3) begin
      errors++;
      $display("FAIL bp_accepted got %0d exp 3", acc);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_in_ready got %b exp 0", bus.in_ready);
    end
    x      = model(1);
    held_e = bus.out_e;
    held_f = bus.out_f;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_e !== EXP_W'(x.e) || bus.out_f !== MAN_W'(x.f) ||
          bus.out_e !== held_e || bus.out_f !== held_f) begin
        errors++;
        $display("FAIL bp_stalled_hold got v=%b e=%0d f=%0d exp v=1 e=%0d f=%0d",
                 bus.out_valid, bus.out_e, bus.out_f, x.e, x.f);
      end
    end
    got = 0;
    for (int c = 0; c < 30 && got < 5; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid  = (acc < 5);
      bus.in_data   = IN_W'(acc + 1);
      #1;
      if (bus.out_valid === 1'b1) begin
        x = model(got + 1);
        checks++;
        if (bus.out_s !== x.s || bus.out_e !== EXP_W'(x.e) ||
            bus.out_f !== MAN_W'(x.f) || bus.out_sat !== x.sat) begin
          errors++;
          $display("FAIL bp_order idx=%0d got e=%0d f=%0d exp e=%0d f=%0d",
                   got, bus.out_e, bus.out_f, x.e, x.f);
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready === 1'b1) acc++;
    end
    checks++;
    if (got != 5) begin
      errors++;
      $display("FAIL bp_count got %0d exp 5", got);
    end
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_duplicate got v=%b exp 0", bus.out_valid);
    end
  endtask

  task automatic test_random;
    exp_t q[$];
    exp_t x;
    bit prev_stall;
    logic p_s, p_sat;
    logic [EXP_W-1:0] p_e;
    logic [MAN_W-1:0] p_f;
    prev_stall = 1'b0;
    p_s = 1'b0; p_sat = 1'b0; p_e = '0; p_f = '0;
    for (int c = 0; c < 340; c++) begin
      @(negedge clk);
      if (c < 300) begin
        bus.in_valid  = ($urandom_range(0, 3) != 0);
        bus.out_ready = ($urandom_range(0, 2) != 0);
        case ($urandom_range(0, 7))
          0:       bus.in_data = 12'h800;
          1:       bus.in_data = 12'h7FF;
          2:       bus.in_data = IN_W'($urandom_range(0, 40));
          default: bus.in_data = IN_W'($urandom);
        endcase
      end else begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
      end
      #1;
      if (prev_stall) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_s !== p_s || bus.out_e !== p_e ||
            bus.out_f !== p_f || bus.out_sat !== p_sat) begin
          errors++;
          $display("FAIL rand_stall_stable cyc=%0d got v=%b e=%0d f=%0d exp v=1 e=%0d f=%0d",
                   c, bus.out_valid, bus.out_e, bus.out_f, p_e, p_f);
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_unexpected_output cyc=%0d got e=%0d f=%0d exp none",
                   c, bus.out_e, bus.out_f);
        end else begin
          x = q.pop_front();
          if (bus.out_s !== x.s || bus.out_e !== EXP_W'(x.e) ||
              bus.out_f !== MAN_W'(x.f) || bus.out_sat !== x.sat) begin
            errors++;
            $display("FAIL rand_fields cyc=%0d got s=%b e=%0d f=%0d sat=%b exp s=%b e=%0d f=%0d sat=%b",
                     c, bus.out_s, bus.out_e, bus.out_f, bus.out_sat, x.s, x.e, x.f, x.sat);
          end
        end
      end
      if (bus.in_valid && bus.in_ready === 1'b1) q.push_back(model(to_int(bus.in_data)));
      prev_stall = (bus.out_valid === 1'b1) && !bus.out_ready;
      p_s = bus.out_s; p_e = bus.out_e; p_f = bus.out_f; p_sat = bus.out_sat;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL rand_drain got %0d pending exp 0", q.size());
    end
  endtask

  task automatic test_midstream_reset;
    exp_t x;
    int lat;
    @(negedge clk);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = IN_W'(100 + i);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_e !== '0 || bus.out_f !== '0) begin
      errors++;
      $display("FAIL rst_flush got v=%b e=%0d f=%0d exp 0", bus.out_valid, bus.out_e, bus.out_f);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_no_partial cyc=%0d got v=%b exp 0", c, bus.out_valid);
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 12'hE5A;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      if (bus.out_valid === 1'b1) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    x = model(-422);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL rst_restart_latency got %0d exp 3", lat);
    end
    checks++;
    if (bus.out_s !== x.s || bus.out_e !== EXP_W'(x.e) || bus.out_f !== MAN_W'(x.f)) begin
      errors++;
      $display("FAIL rst_restart_fields got s=%b e=%0d f=%0d exp s=%b e=%0d f=%0d",
               bus.out_s, bus.out_e, bus.out_f, x.s, x.e, x.f);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_midstream_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/twos_to_float_pipe.md
Name: twos_to_float_pipe

Overview:
- Pipelined, parametrised converter: signed two's-complement integer → compact sign/exponent/significand float.
- Generalises the existing 12-bit sign-magnitude converter:
  - adds normalisation, rounding and most-negative saturation;
  - adds a valid/ready stream interface with backpressure.
- Sits between the sample source and the float packing/display logic.

Parameters:
- IN_W, 12, input word width incl. sign bit; ≥ 4.
- EXP_W, 3, exponent field width.
- MAN_W, 4, significand width; no hidden bit; MSB set unless exponent = 0.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts input this cycle.
- in_data  in  IN_W  two's-complement input D.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_s  out  1  sign.
- out_e  out  EXP_W  exponent E.
- out_f  out  MAN_W  significand F; value = (−1)^S · F · 2^E.
- out_sat  out  1  result was clamped (most-negative input, or round overflow at max E).

Behaviour:
- Definitions: MAG_W = IN_W−1, EMAX = 2^EXP_W−1.
- Elaboration error unless EMAX ≥ MAG_W−MAN_W and MAN_W < MAG_W.
- Reset: all stage valid flags = 0; out_s/out_e/out_f/out_sat = 0; in_ready = 1 after reset.
- Handshake:
  - advance = out_ready | ~out_valid; in_ready = advance.
  - All stage registers load only when advance = 1.
  - Input transfer on in_valid & in_ready; output transfer on out_valid & out_ready.
  - Bubbles propagate with valid = 0.
  - Outputs are held stable while out_valid & ~out_ready.
- Latency: exactly 3 cycles from input transfer to out_valid when never stalled; throughput 1/cycle.
- Stage 1, sign-magnitude:
  - S = D[IN_W−1].
  - M = D[MAG_W−1:0], or (~D+1) truncated to MAG_W when S = 1.
  - D = −2^MAG_W: M = 2^MAG_W−1, sat = 1.
- Stage 2, normalise:
  - lz = leading zeros of M within MAG_W (lz = MAG_W for M = 0).
  - Eraw = MAG_W−MAN_W−lz.
  - Eraw ≤ 0: E = 0, F = M[MAN_W−1:0], round bit = 0.
  - Otherwise E = Eraw; F = the MAN_W bits starting at the leading one; round bit = the next lower bit.
- Stage 3, round (see Optional Feature) and register outputs:
  - F + 1 wrapping to 0 with E < EMAX: F = 2^(MAN_W−1), E+1.
  - F + 1 wrapping to 0 with E = EMAX: F = all ones, E = EMAX, sat = 1.
- Zero input: S = 0, E = 0, F = 0, sat = 0.
- Reset asserted mid-stream flushes all in-flight words; no partial output.

Optional Feature:
- Macro TWOS_FLOAT_ROUND_EN.
- Defined: round-half-up; F += round bit, with the carry rules of stage 3.
- Undefined: truncate; round bit ignored; sat only from most-negative input.
- Latency and handshake are identical in both builds.

Decomposition:
- Package twos_float_pkg:
  - localparams MAG_W, EMAX, LZ_W = $clog2(MAG_W+1);
  - typedef for the stage-payload struct {s, e, f, rnd, sat}.
- One sub-module, twos_float_lzc: parametrised combinational leading-zero counter (width MAG_W, output LZ_W), instantiated in stage 2.

Test Plan:
- in_data = 422 → S = 0, E = 5, F = 13 (416), sat = 0, out_valid exactly 3 cycles after transfer.
- in_data = −422 (0xE5A) → S = 1, E = 5, F = 13.
- in_data = 125:
  - with ROUND_EN → E = 4, F = 8 (128);
  - without → E = 3, F = 15 (120).
- Extremes:
  - in_data = 2047 with ROUND_EN → E = 7, F = 15, sat = 1;
  - in_data = 0x800 → S = 1, E = 7, F = 15, sat = 1;
  - in_data = 5 → E = 0, F = 5;
  - in_data = 0 → all fields 0.
- Backpressure:
  - stream 1, 2, 3, 4, 5 with out_ready = 0 → in_ready drops after 3 accepted;
  - release → outputs in order, none lost or duplicated, fields stable while stalled.
- Reset:
  - assert rst_n = 0 with 3 words in flight → out_valid = 0 immediately;
  - after release, first new input emerges 3 cycles later.
